// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive stages.
// Frame width, idle line level and receiver state encoding.
package uart_pkg;

  localparam int DATABITS = 8;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAITHIGH
  } state_t;

endpackage

// File: rtl/sync_bit.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops come out of reset at RESET_VAL.
module sync_bit #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/receive.sv
// 8N1 UART receiver with mid-bit sampling and a single-entry
// holding register (valid/ack) plus overrun/framing-error pulses.
module receive
  import uart_pkg::*;
#(
  parameter int clockperbit = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rx,
  input  logic                rxack,
  output logic [DATABITS-1:0] rxdata,
  output logic                rxvalid,
  output logic                frameerror,
  output logic                overrun
);

  localparam int CW = $clog2(clockperbit);
  localparam logic [CW-1:0] HALF_M1 = CW'(clockperbit / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(clockperbit - 1);

  state_t state;
  state_t state_n;

  logic                rx_s;
  logic [CW-1:0]       cnt;
  logic [2:0]          bitidx;
  logic [DATABITS-1:0] shreg;

  logic tick;
  logic go_start;
  logic go_data;
  logic shift;
  logic good;
  logic ferr;

  sync_bit #(
    .RESET_VAL(LINE_IDLE)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  assign tick = (cnt == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (!rx_s) state_n = START;
      START:    if (tick) state_n = rx_s ? IDLE : DATA;
      DATA:     if (tick && bitidx == 3'd7) state_n = STOP;
      STOP:     if (tick) state_n = rx_s ? IDLE : WAITHIGH;
      WAITHIGH: if (rx_s) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    go_start = 1'b0;
    go_data  = 1'b0;
    shift    = 1'b0;
    good     = 1'b0;
    ferr     = 1'b0;
    unique case (1'b1)
      (state == IDLE):  go_start = !rx_s;
      (state == START): go_data  = tick && !rx_s;
      (state == DATA):  shift    = tick;
      (state == STOP): begin
        good = tick && rx_s;
        ferr = tick && !rx_s;
      end
      default: ;
    endcase
  end

  // Counter free-runs downward; only transitions reload it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      bitidx <= '0;
      shreg  <= '0;
    end else begin
      if (go_start)              cnt <= HALF_M1;
      else if (go_data || shift) cnt <= FULL_M1;
      else                       cnt <= cnt - CW'(1);
      if (go_data)    bitidx <= '0;
      else if (shift) bitidx <= bitidx + 3'd1;
      if (shift) shreg <= {rx_s, shreg[DATABITS-1:1]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rxdata     <= '0;
      rxvalid    <= 1'b0;
      frameerror <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (good) rxdata <= shreg;
      if (good)       rxvalid <= 1'b1;
      else if (rxack) rxvalid <= 1'b0;
      frameerror <= ferr;
      overrun    <= good && rxvalid && !rxack;
    end
  end

endmodule

// File: tb/tb_receive.sv
// Scoreboard bench for the UART receiver: serialized frames,
// expected events queued by a reference model, checked by a monitor.
module tb_receive;

  localparam int CPB  = 10;
  localparam int DONE = 2 + CPB / 2 + 9 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rxack = 1'b0;
  logic [7:0] rxdata;
  logic       rxvalid;
  logic       frameerror;
  logic       overrun;

  receive #(
    .clockperbit(CPB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .rxack     (rxack),
    .rxdata    (rxdata),
    .rxvalid   (rxvalid),
    .frameerror(frameerror),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  typedef enum int {K_GOOD, K_OVR, K_FERR} kind_t;
  typedef struct {
    kind_t      kind;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  exp_t       m_e;
  int         errors = 0;
  int         checks = 0;
  bit         model_valid = 1'b0;
  int         wait_cyc = 0;
  logic       pv = 1'b0;
  logic [7:0] pd = 8'h00;
  kind_t      act_kind;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle(int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic ack();
    rxack = 1'b1;
    @(negedge clock);
    rxack = 1'b0;
    model_valid = 1'b0;
  endtask

  // Drives one frame starting at a negedge; abort_at >= 0 pulls
  // reset low at that bit-time offset and abandons the frame.
  task automatic send(logic [7:0] b, bit stop, bit ack_first,
                      bit ack_end, int abort_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    if (abort_at < 0) begin
      if (ack_first) model_valid = 1'b0;
      if (!stop) begin
        q.push_back('{K_FERR, b});
      end else begin
        if (model_valid && !ack_end) q.push_back('{K_OVR, b});
        else q.push_back('{K_GOOD, b});
        model_valid = 1'b1;
      end
    end
    for (int e = 0; e < 10 * CPB; e++) begin
      if (e == abort_at) begin
        reset = 1'b0;
        #1;
        chk("midrst_rxvalid", int'(rxvalid), 0);
        chk("midrst_rxdata", int'(rxdata), 0);
        chk("midrst_ferr", int'(frameerror), 0);
        chk("midrst_ovr", int'(overrun), 0);
        model_valid = 1'b0;
        @(negedge clock);
        rx = 1'b1;
        rxack = 1'b0;
        reset = 1'b1;
        return;
      end
      rx = bits[e / CPB];
      rxack = (ack_first && e == 0) || (ack_end && e == DONE);
      @(negedge clock);
    end
    rxack = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      wait_cyc = 0;
    end else if (frameerror || overrun ||
                 (rxvalid && (!pv || rxdata != pd))) begin
      act_kind = frameerror ? K_FERR : (overrun ? K_OVR : K_GOOD);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got kind %0d data %0h required none",
                 act_kind, rxdata);
      end else begin
        m_e = q.pop_front();
        chk("event_kind", int'(act_kind), int'(m_e.kind));
        if (act_kind != K_FERR) chk("event_data", int'(rxdata), int'(m_e.data));
        if (act_kind == K_OVR) chk("ovr_valid", int'(rxvalid), 1);
      end
      wait_cyc = 0;
    end else if (q.size() > 0) begin
      wait_cyc++;
      if (wait_cyc > 11 * CPB) begin
        m_e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL timeout: got no event required kind %0d data %0h",
                 m_e.kind, m_e.data);
        wait_cyc = 0;
      end
    end else begin
      wait_cyc = 0;
    end
    pv = rxvalid;
    pd = rxdata;
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_rxvalid", int'(rxvalid), 0);
    chk("rst_rxdata", int'(rxdata), 0);
    chk("rst_ferr", int'(frameerror), 0);
    chk("rst_ovr", int'(overrun), 0);
    reset = 1'b1;
    idle(5);

    send(8'hA5, 1'b1, 1'b0, 1'b0, -1);
    idle(3);
    ack();

    rx = 1'b0;
    repeat (3) @(negedge clock);
    idle(20);
    send(8'h3C, 1'b1, 1'b0, 1'b0, -1);
    ack();

    send(8'h55, 1'b0, 1'b0, 1'b0, -1);
    rx = 1'b0;
    repeat (30) @(negedge clock);
    idle(5);
    send(8'h81, 1'b1, 1'b0, 1'b0, -1);
    ack();

    send(8'h11, 1'b1, 1'b0, 1'b0, -1);
    send(8'h22, 1'b1, 1'b0, 1'b0, -1);
    ack();
    idle(2);
    send(8'h11, 1'b1, 1'b0, 1'b0, -1);
    send(8'h22, 1'b1, 1'b0, 1'b1, -1);
    idle(2);
    chk("ackend_valid", int'(rxvalid), 1);
    ack();

    send(8'h00, 1'b1, 1'b1, 1'b0, -1);
    send(8'hFF, 1'b1, 1'b1, 1'b0, -1);
    send(8'h3C, 1'b1, 1'b1, 1'b0, -1);
    idle(2);

    send(8'hF0, 1'b1, 1'b0, 1'b0, 5 * CPB + 3);
    idle(5 * CPB);
    chk("post_rst_valid", int'(rxvalid), 0);
    send(8'h0F, 1'b1, 1'b0, 1'b0, -1);
    ack();

    for (int i = 0; i < 20; i++) begin
      send(8'($urandom), 1'b1, 1'($urandom_range(0, 1)), 1'b0, -1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 5));
    end

    idle(30);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/receive.md
# receive

UART receiver for the serial link: recovers 8N1 frames (start bit 0, 8 data bits LSB first, stop bit 1, `clockperbit` clocks per bit) from an asynchronous `rx` line and presents each byte on a parallel output. Sits at the far end of the line driven by the transmit stage. Feeds the command/byte consumer through a single-entry holding register with a valid/ack handshake and overrun/framing-error flags.

## Interface

- `clockperbit`, default 10: clocks per bit; must be ≥ 4. `half` = floor(`clockperbit`/2).
- `clock`  in  1  system clock; everything updates on the rising edge.
- `reset`  in  1  asynchronous, active-low: the block is held in reset while `reset` = 0.
- `rx`  in  1  serial line, asynchronous to `clock`, idles high.
- `rxack`  in  1  consumer has taken `rxdata`; clears `rxvalid`.
- `rxdata`  out  8  last good byte; holds until the next good frame overwrites it.
- `rxvalid`  out  1  level; set on a good frame, cleared by `rxack`.
- `frameerror`  out  1  one-cycle pulse; stop bit sampled 0.
- `overrun`  out  1  one-cycle pulse; a good frame completed while `rxvalid` was already 1 and `rxack` was 0.

## Operation

- `rx` passes through a 2-flop synchronizer (both flops reset to 1) to give `rx_s`. Only `rx_s` is used internally.
- Counter `cnt` has width $clog2(`clockperbit`) and always counts down. A **tick** occurs in any cycle where `cnt` = 0; the tick reloads the counter per the transition below.
- Bit index `bitidx` is 3 bits. Shift register `shreg` is 8 bits and shifts right, with the new bit entering at the MSB.
- States and transitions:
  - **IDLE**: if `rx_s` = 0, go to START with `cnt` ← `half`−1.
  - **START**: on tick, if `rx_s` = 1 (false start), go to IDLE and produce no output. Otherwise go to DATA with `cnt` ← `clockperbit`−1 and `bitidx` ← 0.
  - **DATA**: on tick, shift `rx_s` into `shreg` and reload `cnt` ← `clockperbit`−1. On the tick with `bitidx` = 7, go to STOP; otherwise increment `bitidx`.
  - **STOP**: on tick:
    - `rx_s` = 1: `rxdata` ← `shreg`, `rxvalid` ← 1, go to IDLE.
    - `rx_s` = 0: pulse `frameerror`, leave `rxdata` and `rxvalid` unchanged, go to WAITHIGH.
  - **WAITHIGH**: stay until `rx_s` = 1, then go to IDLE. This keeps a break condition from re-triggering.
- `rxvalid` logic, next value:
  - good-frame completion: 1;
  - otherwise `rxack`: 0;
  - otherwise hold.
- `overrun` pulses when a good frame completes while `rxvalid` = 1 and `rxack` = 0. The new byte overwrites `rxdata`.
- Good-frame completion and `rxack` in the same cycle: `rxvalid` stays 1, no overrun.
- `rxack` while `rxvalid` = 0 is ignored.

## Timing

- Reset values:
  - state IDLE;
  - `cnt`, `bitidx`, `shreg` = 0;
  - sync flops = 1;
  - `rxdata` = 0x00;
  - `rxvalid`, `frameerror`, `overrun` = 0.
- Reset mid-frame discards the partial byte; reception restarts on the next low `rx_s`.
- Cycle numbering: E0 is the first rising edge at which the `rx` pin is 0.
  - E2: START is entered.
  - E(2+`half`): start-bit sample.
  - E(2+`half`+k·`clockperbit`), k = 1…8: data bit k−1.
  - E(2+`half`+9·`clockperbit`): stop sample.
- `rxvalid`, `frameerror` and `overrun` are registered: they are visible right after the stop-sample edge. With `clockperbit` = 10 that edge is E97.
- A new frame may start the cycle after returning to IDLE, so back-to-back frames with zero idle time are accepted.
- Error tolerance: sampling is at mid-bit plus 2 sync cycles.

## Structure

- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, WAITHIGH);
  - `DATABITS` = 8;
  - idle line level = 1.
  - The transmit stage shares `DATABITS` and the line level.
- Sub-module `sync_bit`: 2-flop synchronizer with a reset-value parameter. It is reusable for other asynchronous inputs.

## Test plan

- Good frame: `clockperbit` = 10, drive 0xA5 as 8N1 starting at E0. Required: `rxvalid` rises after E97 with `rxdata` = 0xA5; `frameerror` = 0 and `overrun` = 0 throughout.
- False start: `rx` low for 3 cycles, then high. Required: no `rxvalid` and no `frameerror`; state returns to IDLE; a following 0x3C frame is received correctly.
- Framing error: 0x55 with stop bit 0, line held low 30 more cycles, then high, then 0x81. Required: one `frameerror` pulse; `rxvalid` stays 0 and no frame is started while low; 0x81 is then received.
- Overrun/ack: two frames 0x11 then 0x22 with no `rxack`. Required: one `overrun` pulse and `rxdata` = 0x22. Repeat with `rxack` asserted exactly at completion of 0x22: `rxvalid` stays 1 and no overrun.
- Loopback: transmit stage → `rx`, bytes 0x00, 0xFF, 0x3C back-to-back. Required: three `rxvalid` events, acked each time, with matching data.
- Reset mid-frame: assert `reset` = 0 during data bit 4 of 0xF0. Required: all outputs and state return to reset values immediately; no `rxvalid`; the next 0x0F frame is received correctly.
